noc_packet_injector: RTL and testbench

Requester-side counterpart of the five-port router arbiter. It sits between a local core (or an upstream input buffer) and one arbiter request port. It takes a packet descriptor plus a payload word stream and segments them into header/body/tail flits. It drives req, flit_id and length toward the arbiter and transmits flits only while that port's one-hot grant bit is high.

---
 rtl/noc_pkg.sv | 47 ++++
 rtl/noc_flit_out_reg.sv | 42 ++++
 rtl/noc_packet_injector.sv | 113 +++++++++++
 tb/tb_noc_packet_injector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, length width, port indices, arbiter states.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package noc_pkg;

  localparam int LEN_W = 12;

  // flit_id codes seen by the arbiter
  localparam logic [2:0] FLIT_IDLE = 3'b000;
  localparam logic [2:0] FLIT_HEAD = 3'b001;
  localparam logic [2:0] FLIT_BODY = 3'b010;
  localparam logic [2:0] FLIT_TAIL = 3'b100;

  // Router port indices
  typedef enum logic [2:0] {
    PORT_L = 3'd0,
    PORT_N = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_S = 3'd4
  } port_e;

  // One-hot arbiter state vector encodings (bit position = port index)
  localparam logic [4:0] ARB_IDLE = 5'b00000;
  localparam logic [4:0] ARB_L    = 5'b00001;
  localparam logic [4:0] ARB_N    = 5'b00010;
  localparam logic [4:0] ARB_E    = 5'b00100;
  localparam logic [4:0] ARB_W    = 5'b01000;
  localparam logic [4:0] ARB_S    = 5'b10000;

  // Injector sequencing states
  typedef enum logic [1:0] {
    INJ_IDLE = 2'd0,
    INJ_HEAD = 2'd1,
    INJ_BODY = 2'd2,
    INJ_DONE = 2'd3
  } inj_state_e;

  // Timeout length for the arbiter timer: len + extra, saturated at the field maximum
  function automatic logic [LEN_W-1:0] timeout_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W:0]   extra);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + extra;
    return sum[LEN_W] ? {LEN_W{1'b1}} : sum[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/noc_flit_out_reg.sv
// Output flit holding register (valid/data/id) with load, transfer and hold behaviour.
// Latency: a load appears on the outputs one cycle later; clear takes effect next edge.
// Backpressure: contents hold stable while valid and grant is low; transfer on valid && grant.
module noc_flit_out_reg
  import noc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grant,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [2:0]        load_id,
  input  logic              clear,
  output logic              flit_valid,
  output logic [DATA_W-1:0] flit_data,
  output logic [2:0]        flit_id,
  output logic              xfer
);

  assign xfer = flit_valid && grant;

  // Clear wins, then a new load, then drain on transfer; otherwise hold everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_valid <= 1'b0;
      flit_data  <= '0;
      flit_id    <= FLIT_IDLE;
    end else if (clear) begin
      flit_valid <= 1'b0;
      flit_id    <= FLIT_IDLE;
    end else if (load) begin
      flit_valid <= 1'b1;
      flit_data  <= load_data;
      flit_id    <= load_id;
    end else if (xfer) begin
      flit_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_packet_injector.sv
// Segments a descriptor plus payload stream into head/body/tail flits for one arbiter port.
// Latency: header presented the cycle after descriptor accept; flits stream one per granted cycle.
// Backpressure: flits hold while grant is low; pl_ready drops when the held flit cannot move.
module noc_packet_injector
  import noc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SLACK  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [DATA_W-1:0] pkt_hdr,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              grant,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [LEN_W-1:0]  length,
  output logic              flit_valid,
  output logic [DATA_W-1:0] flit_data,
  output logic              err_len
);

  localparam logic [LEN_W:0] LEN_EXTRA = (LEN_W+1)'(SLACK + 1);

  inj_state_e        state;
  logic [LEN_W-1:0]  remaining;   // payload words not yet loaded into the output register
  logic              xfer;
  logic              head_load;
  logic              pl_load;
  logic              out_load;
  logic              out_clear;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_id;

  assign pkt_ready = (state == INJ_IDLE);

  // Payload may be pulled while the header is leaving too, so body(1) follows head with no gap.
  // Once the tail is loaded remaining is zero and no further words are taken.
  assign pl_ready  = ((state == INJ_HEAD) || (state == INJ_BODY)) &&
                     (remaining != '0) && (!flit_valid || grant);

  assign head_load = pkt_valid && pkt_ready && (pkt_len != '0);
  assign pl_load   = pl_valid && pl_ready;
  assign out_load  = head_load || pl_load;
  assign out_data  = head_load ? pkt_hdr : pl_data;
  assign out_id    = head_load ? FLIT_HEAD :
                     ((remaining == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY);
  assign out_clear = (state == INJ_BODY) && xfer && (flit_id == FLIT_TAIL);

  noc_flit_out_reg #(
    .DATA_W (DATA_W)
  ) u_flit_out_reg (
    .clk        (clk),
    .rst        (rst),
    .grant      (grant),
    .load       (out_load),
    .load_data  (out_data),
    .load_id    (out_id),
    .clear      (out_clear),
    .flit_valid (flit_valid),
    .flit_data  (flit_data),
    .flit_id    (flit_id),
    .xfer       (xfer)
  );

  // Packet sequencing: descriptor accept, header, body/tail streaming, one-cycle release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INJ_IDLE;
      req       <= 1'b0;
      length    <= '0;
      err_len   <= 1'b0;
      remaining <= '0;
    end else begin
      err_len <= 1'b0;
      case (state)
        INJ_IDLE: begin
          if (pkt_valid) begin
            if (pkt_len == '0) begin
              err_len <= 1'b1;
            end else begin
              remaining <= pkt_len;
              length    <= timeout_len(pkt_len, LEN_EXTRA);
              req       <= 1'b1;
              state     <= INJ_HEAD;
            end
          end
        end
        INJ_HEAD: begin
          if (pl_load) remaining <= remaining - 1'b1;
          if (xfer)    state     <= INJ_BODY;
        end
        INJ_BODY: begin
          if (pl_load) remaining <= remaining - 1'b1;
          if (out_clear) begin
            req   <= 1'b0;
            state <= INJ_DONE;
          end
        end
        INJ_DONE: begin
          state <= INJ_IDLE;
        end
        default: state <= INJ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector: per-cycle vector table plus hand sequences.
// Latency: n/a.
// Backpressure: grant and pl_valid are driven directly from the vectors.
module tb_noc_packet_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [11:0] pkt_len;
  logic [31:0] pkt_hdr;
  logic        pl_valid;
  logic        pl_ready;
  logic [31:0] pl_data;
  logic        grant;
  logic        req;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic        flit_valid;
  logic [31:0] flit_data;
  logic        err_len;

  int checks   = 0;
  int failures = 0;

  noc_packet_injector #(
    .DATA_W (32),
    .SLACK  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_len    (pkt_len),
    .pkt_hdr    (pkt_hdr),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_data    (pl_data),
    .grant      (grant),
    .req        (req),
    .flit_id    (flit_id),
    .length     (length),
    .flit_valid (flit_valid),
    .flit_data  (flit_data),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [2:0]  flit_id;
    logic [11:0] length;
    logic        flit_valid;
    logic [31:0] flit_data;
    logic        err_len;
    logic        pkt_ready;
    logic        pl_ready;
  } out_t;

  typedef struct packed {
    logic        pkt_valid;
    logic [11:0] pkt_len;
    logic [31:0] pkt_hdr;
    logic        pl_valid;
    logic [31:0] pl_data;
    logic        grant;
    out_t        exp;
    logic        chk_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pv, logic [11:0] ln, logic [31:0] hd,
                              logic plv, logic [31:0] pd, logic g,
                              logic r, logic [2:0] id, logic [11:0] lg, logic fv,
                              logic [31:0] fd, logic cd, logic e, logic pr, logic plr);
    vec_t v;
    v.pkt_valid = pv;  v.pkt_len = ln;  v.pkt_hdr = hd;
    v.pl_valid  = plv; v.pl_data = pd;  v.grant   = g;
    v.exp.req = r; v.exp.flit_id = id; v.exp.length = lg; v.exp.flit_valid = fv;
    v.exp.flit_data = fd; v.exp.err_len = e; v.exp.pkt_ready = pr; v.exp.pl_ready = plr;
    v.chk_data = cd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.req = req; o.flit_id = flit_id; o.length = length; o.flit_valid = flit_valid;
    o.flit_data = flit_data; o.err_len = err_len; o.pkt_ready = pkt_ready; o.pl_ready = pl_ready;
    return o;
  endfunction

  initial begin
    out_t act;
    out_t exp;
    int   word, nh, nb, nt, seq_err;
    logic [31:0] exp_body, tail_data;
    logic [11:0] head_len;
    logic done, hs, found;

    rst = 1'b0; pkt_valid = 1'b0; pkt_len = '0; pkt_hdr = '0;
    pl_valid = 1'b0; pl_data = '0; grant = 1'b0;

    // ---------------- vector table ----------------
    // pkt_len=3, hdr A5, payload 1..3, grant one cycle after req
    vecs.push_back(mk(1, 3, 'hA5, 0, 0, 0,   0, 3'b000, 0, 0, 0,     1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,    1, 1, 0,   1, 3'b001, 6, 1, 'hA5,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    1, 1, 1,   1, 3'b001, 6, 1, 'hA5,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    1, 2, 1,   1, 3'b010, 6, 1, 1,     1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    1, 3, 1,   1, 3'b010, 6, 1, 2,     1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    1, 3, 1,   1, 3'b100, 6, 1, 3,     1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 1,   0, 3'b000, 6, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,   0, 3'b000, 6, 0, 0,     0, 0, 1, 0));
    // zero-length descriptor
    vecs.push_back(mk(1, 0, 'hDEAD, 0, 0, 0, 0, 3'b000, 6, 0, 0,     0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,   0, 3'b000, 6, 0, 0,     0, 1, 1, 0));
    // pkt_len=4, grant lost for 5 cycles after body(1)
    vecs.push_back(mk(1, 4, 'h11, 0, 0, 0,   0, 3'b000, 6, 0, 0,     0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,    1, 1, 1,   1, 3'b001, 7, 1, 'h11,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    1, 2, 1,   1, 3'b010, 7, 1, 1,     1, 0, 0, 1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0,  1, 3, 0,   1, 3'b010, 7, 1, 2,     1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    1, 3, 1,   1, 3'b010, 7, 1, 2,     1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    1, 4, 1,   1, 3'b010, 7, 1, 3,     1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    0, 0, 1,   1, 3'b100, 7, 1, 4,     1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 1,   0, 3'b000, 7, 0, 0,     0, 0, 0, 0));
    // pkt_len=3, payload gap of 3 cycles between words 1 and 2
    vecs.push_back(mk(1, 3, 'h22, 0, 0, 1,   0, 3'b000, 7, 0, 0,     0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,    1, 'h31, 1, 1, 3'b001, 6, 1, 'h22, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    0, 0, 1,   1, 3'b010, 6, 1, 'h31,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    0, 0, 1,   1, 3'b010, 6, 0, 0,     0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    0, 0, 1,   1, 3'b010, 6, 0, 0,     0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    1, 'h32, 1, 1, 3'b010, 6, 0, 0,    0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    1, 'h33, 1, 1, 3'b010, 6, 1, 'h32, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    0, 0, 1,   1, 3'b100, 6, 1, 'h33,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 1,   0, 3'b000, 6, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,   0, 3'b000, 6, 0, 0,     0, 0, 1, 0));

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 64'({req, flit_id, length, flit_valid, flit_data, err_len}), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // ---------------- apply table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      pkt_valid = vecs[i].pkt_valid; pkt_len = vecs[i].pkt_len; pkt_hdr = vecs[i].pkt_hdr;
      pl_valid  = vecs[i].pl_valid;  pl_data = vecs[i].pl_data; grant   = vecs[i].grant;
      #1;
      act = sample();
      exp = vecs[i].exp;
      if (!vecs[i].chk_data) begin
        act.flit_data = '0;
        exp.flit_data = '0;
      end
      chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
    end

    // ---------------- pkt_len=4095, grant and payload always available ----------------
    word = 1; nh = 0; nb = 0; nt = 0; seq_err = 0; exp_body = 1; tail_data = '0;
    head_len = '0; done = 1'b0;
    @(negedge clk);
    pkt_valid = 1'b1; pkt_len = 12'd4095; pkt_hdr = 'hF00D;
    grant = 1'b1; pl_valid = 1'b1; pl_data = 1;
    @(posedge clk);
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      pkt_valid = 1'b0;
      pl_data   = word;
      #1;
      hs = pl_valid && pl_ready;
      if (flit_valid && grant) begin
        case (flit_id)
          3'b001: begin nh++; head_len = length; end
          3'b010: begin
            nb++;
            if (flit_data != exp_body) seq_err++;
            exp_body++;
          end
          3'b100: begin nt++; tail_data = flit_data; done = 1'b1; end
          default: seq_err++;
        endcase
      end
      @(posedge clk);
      if (hs) word++;
    end
    chk("max_len_done",     64'(done),      64'(1));
    chk("max_len_length",   64'(head_len),  64'(4095));
    chk("max_len_heads",    64'(nh),        64'(1));
    chk("max_len_bodies",   64'(nb),        64'(4094));
    chk("max_len_tails",    64'(nt),        64'(1));
    chk("max_len_order",    64'(seq_err),   64'(0));
    chk("max_len_tail_dat", 64'(tail_data), 64'(4095));
    @(negedge clk);
    pl_valid = 1'b0; grant = 1'b0;
    #1;
    chk("max_len_req_drop", 64'({req, flit_valid}), 64'(0));
    repeat (2) @(negedge clk);

    // ---------------- async reset mid-packet ----------------
    pkt_valid = 1'b1; pkt_len = 12'd3; pkt_hdr = 'h77;
    grant = 1'b1; pl_valid = 1'b1; pl_data = 1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (c > 0) pkt_valid = 1'b0;
      #1;
      if (flit_valid && flit_id == 3'b010 && flit_data == 1) found = 1'b1;
    end
    chk("rst_body1_seen", 64'(found), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_outputs",
        64'({req, flit_id, length, flit_valid, flit_data, err_len}), 64'(0));
    pl_valid = 1'b0; grant = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pkt_valid = 1'b1; pkt_len = 12'd1; pkt_hdr = 'h99;
    grant = 1'b1; pl_valid = 1'b1; pl_data = 'h5A;
    @(negedge clk);
    pkt_valid = 1'b0;
    #1;
    chk("post_rst_head", 64'({req, flit_id, length, flit_valid, flit_data}),
        64'({1'b1, 3'b001, 12'd4, 1'b1, 32'h99}));
    @(negedge clk);
    #1;
    chk("post_rst_tail", 64'({req, flit_id, flit_valid, flit_data, pl_ready}),
        64'({1'b1, 3'b100, 1'b1, 32'h5A, 1'b0}));
    @(negedge clk);
    pl_valid = 1'b0;
    #1;
    chk("post_rst_done", 64'({req, flit_id, flit_valid}), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
